// File: rtl/decoder_rr_arbiter_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared constants, state encoding and round-robin pick helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_GRANT   = GRANT,
        ST_RELEASE = RELEASE
    } state_t;

    // Returns {found, index}; scanning downward lets the smallest offset from ptr win.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_rr_arbiter_dec2to4_n.sv
// ============================================================================
// Module : dec2to4_n
// Brief  : 2-to-4 decoder with enable and active-low outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dec2to4_n (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_en,
    output logic [3:0] o_y_n
);

    always_comb begin
        o_y_n = 4'b1111;
        if (i_en) begin
            o_y_n[{i_a, i_b}] = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
// ============================================================================
// Module : decoder_rr_arbiter
// Brief  : Round-robin arbiter driving a shared active-low 2-to-4 decoder,
//          with break-before-make dead cycle and a per-ownership hold timer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module decoder_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               dec_a,
    output logic               dec_b,
    output logic               dec_en,
    output logic [NUM_REQ-1:0] gnt_n,
    output logic               busy,
    output logic               timeout
);

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_idx;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_en;
    logic                r_timeout;

    logic [IDX_W:0]      w_pick;
    logic                w_found;
    logic [IDX_W-1:0]    w_win;
    logic                w_owner_req;
    logic                w_hold_sat;

    assign w_pick      = rr_pick(req, r_ptr);
    assign w_found     = w_pick[IDX_W];
    assign w_win       = w_pick[IDX_W-1:0];
    assign w_owner_req = req[r_idx];
    assign w_hold_sat  = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_hold_cnt <= '0;
            r_en       <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                // RELEASE is the dead cycle; it re-arbitrates exactly like IDLE.
                ST_IDLE, ST_RELEASE: begin
                    if (w_found) begin
                        r_state    <= ST_GRANT;
                        r_idx      <= w_win;
                        r_en       <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req || w_hold_sat) begin
                        r_state   <= ST_RELEASE;
                        r_en      <= 1'b0;
                        r_ptr     <= r_idx + 2'd1;
                        // An owner dropping on the saturating edge is a normal release.
                        r_timeout <= w_owner_req;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign dec_a   = r_idx[1];
    assign dec_b   = r_idx[0];
    assign dec_en  = r_en;
    assign busy    = (r_state != ST_IDLE);
    assign timeout = r_timeout;

    dec2to4_n u_dec (
        .i_a   (dec_a),
        .i_b   (dec_b),
        .i_en  (dec_en),
        .o_y_n (gnt_n)
    );

endmodule

`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
// ============================================================================
// Module : tb_decoder_rr_arbiter
// Brief  : Scoreboard bench; two arbiters (MAX_HOLD 8 and 1) share stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_decoder_rr_arbiter;

    typedef struct packed {
        logic [3:0] gnt_n;
        logic       a;
        logic       b;
        logic       en;
        logic       busy;
        logic       tmo;
    } obs_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;

    logic [1:0] dec_a, dec_b, dec_en, busy, timeout;
    logic [7:0] gnt_n;

    int checks = 0;
    int errors = 0;

    obs_t q0[$];
    obs_t q1[$];

    int m_owner [2];
    int m_held  [2];
    int m_ptr   [2];
    int m_last  [2];
    bit m_gap   [2];
    int max_hold[2] = '{8, 1};

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .dec_a(dec_a[0]), .dec_b(dec_b[0]), .dec_en(dec_en[0]),
        .gnt_n(gnt_n[3:0]), .busy(busy[0]), .timeout(timeout[0])
    );

    decoder_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .dec_a(dec_a[1]), .dec_b(dec_b[1]), .dec_en(dec_en[1]),
        .gnt_n(gnt_n[7:4]), .busy(busy[1]), .timeout(timeout[1])
    );

    function automatic obs_t actual(input int n);
        obs_t o;
        o.gnt_n = (n == 0) ? gnt_n[3:0] : gnt_n[7:4];
        o.a     = dec_a[n];
        o.b     = dec_b[n];
        o.en    = dec_en[n];
        o.busy  = busy[n];
        o.tmo   = timeout[n];
        return o;
    endfunction

    task automatic check(input string name, input int n, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual gnt_n=%b a=%b b=%b en=%b busy=%b tmo=%b required gnt_n=%b a=%b b=%b en=%b busy=%b tmo=%b",
                     name, n, $time, act.gnt_n, act.a, act.b, act.en, act.busy, act.tmo,
                     exp.gnt_n, exp.a, exp.b, exp.en, exp.busy, exp.tmo);
        end
    endtask

    // Reference: first requester found walking from ptr, modulo 4.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int off = 0; off < 4; off++) begin
            if (r[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_owner[n] = -1;
            m_held[n]  = 0;
            m_ptr[n]   = 0;
            m_last[n]  = 0;
            m_gap[n]   = 1'b0;
        end
    endtask

    // Advance both models by one clock edge with request vector r and queue the result.
    task automatic model_step(input logic [3:0] r);
        for (int n = 0; n < 2; n++) begin
            obs_t e;
            bit   tmo;
            int   w;
            tmo = 1'b0;
            if (m_owner[n] >= 0) begin
                if (!r[m_owner[n]] || m_held[n] == max_hold[n]) begin
                    tmo        = r[m_owner[n]];
                    m_ptr[n]   = (m_owner[n] + 1) % 4;
                    m_owner[n] = -1;
                    m_gap[n]   = 1'b1;
                end else begin
                    m_held[n]++;
                end
            end else begin
                m_gap[n] = 1'b0;
                w = pick(r, m_ptr[n]);
                if (w >= 0) begin
                    m_owner[n] = w;
                    m_held[n]  = 1;
                    m_last[n]  = w;
                end
            end
            e.gnt_n = (m_owner[n] >= 0) ? ~(4'b0001 << m_owner[n]) : 4'b1111;
            e.a     = m_last[n][1];
            e.b     = m_last[n][0];
            e.en    = (m_owner[n] >= 0);
            e.busy  = (m_owner[n] >= 0) || m_gap[n];
            e.tmo   = tmo;
            if (n == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic cyc(input logic [3:0] r);
        @(negedge clk);
        req = r;
        model_step(r);
    endtask

    task automatic check_reset_state(input string name);
        obs_t z;
        z = '{gnt_n: 4'b1111, a: 1'b0, b: 1'b0, en: 1'b0, busy: 1'b0, tmo: 1'b0};
        for (int n = 0; n < 2; n++) check(name, n, actual(n), z);
    endtask

    // Reset lands between clock edges so the outputs must clear without a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per edge and checks the grant invariants.
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int n = 0; n < 2; n++) begin
                    a = actual(n);
                    checks++;
                    if ($countones(~a.gnt_n) > 1 || (!a.en && a.gnt_n != 4'b1111)) begin
                        errors++;
                        $display("FAIL invariant inst%0d t=%0t actual gnt_n=%b en=%b required at most one low bit and 1111 when disabled",
                                 n, $time, a.gnt_n, a.en);
                    end
                    if (n == 0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        check("scoreboard", n, a, e);
                    end else if (n == 1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        check("scoreboard", n, a, e);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual still running required finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        int         len;

        model_reset();
        #3;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single request, then release into IDLE through the dead cycle.
        repeat (2) cyc(4'b0100);
        repeat (3) cyc(4'b0000);

        // All four requesting: rotation with hold timeouts.
        repeat (45) cyc(4'b1111);
        repeat (3) cyc(4'b0000);

        // Owner 2 leaves ptr at 3, so 0011 must wrap to requester 0.
        async_reset();
        repeat (2) cyc(4'b0100);
        repeat (2) cyc(4'b0000);
        repeat (3) cyc(4'b0011);
        repeat (3) cyc(4'b0000);

        // Lone requester hits the hold limit and is regranted after the gap.
        repeat (20) cyc(4'b0001);
        repeat (3) cyc(4'b0000);

        // Reset in the middle of a grant to requester 1, then regrant.
        async_reset();
        repeat (3) cyc(4'b0010);
        async_reset();
        repeat (3) cyc(4'b0010);
        repeat (3) cyc(4'b0000);

        // Owner releases on the same edge the counter saturates.
        repeat (8) cyc(4'b0001);
        repeat (3) cyc(4'b0000);

        repeat (120) begin
            r   = 4'($urandom);
            len = $urandom_range(1, 6);
            repeat (len) cyc(r);
        end
        repeat (3) cyc(4'b0000);

        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain actual pending=%0d/%0d required 0/0", q0.size(), q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
